// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranging sequencer: trigger pulse, echo timing,
// Avalon-MM status/width/count/control registers and level interrupt.
module hcsr04_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        trig_in,
  input  logic        echo,
  output logic        trig_out,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRIG = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_MEAS = 2'd3;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  logic        echo_meta_q, echo_s_q, echo_prev_q;
  logic        trig_d_q;
  logic [1:0]  state_q, state_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] width_q, width_d;
  logic [31:0] count_q, count_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        ie_q, ie_d;
  logic        trig_out_q, trig_out_d;

  logic wr_en, sw_start, start, w1c;
  logic echo_rise, tmo_hit, busy;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  assign wr_en     = chipselect & ~write_n;
  assign sw_start  = wr_en & (address == 2'd3) & writedata[1];
  assign start     = (trig_in & ~trig_d_q) | sw_start;
  assign w1c       = wr_en & (address == 2'd0) & writedata[1];
  assign echo_rise = echo_s_q & ~echo_prev_q;
  assign tmo_hit   = (tcnt_q == TMO_LAST);
  assign busy      = (state_q != ST_IDLE);

  assign trig_out = trig_out_q;
  assign irq      = done_q & ie_q;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    wcnt_d     = wcnt_q;
    width_d    = width_q;
    count_d    = count_q;
    done_d     = done_q & ~w1c;
    timeout_d  = timeout_q & ~w1c;
    ie_d       = ie_q;
    trig_out_d = 1'b0;
    if (wr_en && address == 2'd3) begin
      ie_d = writedata[0];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_TRIG;
          tcnt_d     = '0;
          trig_out_d = 1'b1;
        end
      end
      ST_TRIG: begin
        trig_out_d = 1'b1;
        tcnt_d     = tcnt_q + 32'd1;
        if (tcnt_q == TRIG_LAST) begin
          trig_out_d = 1'b0;
          tcnt_d     = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + 32'd1;
        if (tmo_hit) begin
          width_d   = '0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          count_d   = count_q + 32'd1;
          state_d   = ST_IDLE;
        end else if (echo_rise) begin
          wcnt_d  = 32'd1;
          state_d = ST_MEAS;
        end
      end
      ST_MEAS: begin
        tcnt_d = tcnt_q + 32'd1;
        // A falling echo beats a coincident timeout.
        if (!echo_s_q) begin
          width_d = wcnt_q;
          done_d  = 1'b1;
          count_d = count_q + 32'd1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          width_d   = '0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          count_d   = count_q + 32'd1;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
      trig_d_q    <= 1'b0;
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      wcnt_q      <= '0;
      width_q     <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ie_q        <= 1'b0;
      trig_out_q  <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
      trig_d_q    <= trig_in;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      wcnt_q      <= wcnt_d;
      width_q     <= width_d;
      count_q     <= count_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      ie_q        <= ie_d;
      trig_out_q  <= trig_out_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = {29'd0, timeout_q, done_q, busy};
      2'd1: readdata = width_q;
      2'd2: readdata = count_q;
      2'd3: readdata = {31'd0, ie_q};
    endcase
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed + randomized bench for hcsr04_ranger against an
// outcome-level model (echo timing -> width/status/count).
module tb_hcsr04_ranger;

  localparam int TRIG = 500;
  localparam int TMO  = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        trig_in = 1'b0;
  logic        echo = 1'b0;
  logic        trig_out;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int hi_len = 0;
  int last_len = 0;
  int pulses = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  hcsr04_ranger #(
    .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .trig_in(trig_in),
    .echo(echo),
    .trig_out(trig_out),
    .irq(irq)
  );

  // Trigger pulse monitor: length of each high run and pulse count.
  always @(negedge clk) begin
    if (trig_out) begin
      hi_len <= hi_len + 1;
    end else if (hi_len != 0) begin
      last_len <= hi_len;
      pulses   <= pulses + 1;
      hi_len   <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic hw_start();
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
  endtask

  task automatic wait_fall(input int p0);
    int n;
    n = 0;
    while (pulses == p0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("trig_pulses", 32'(pulses - p0), 32'd1);
    chk("trig_len", 32'(last_len), 32'(TRIG));
  endtask

  task automatic wait_idle(input int budget, output int n);
    logic [31:0] v;
    n = 0;
    rd(2'd0, v);
    while (v[0] && n < budget) begin
      tick(1);
      n++;
      rd(2'd0, v);
    end
    chk("idle_reached", {31'd0, v[0]}, 32'd0);
  endtask

  task automatic pulse_echo(input int d, input int h);
    tick(d);
    echo = 1'b1;
    tick(h);
    echo = 1'b0;
  endtask

  // Expected outcome: success with width h unless echo ends past timeout.
  task automatic check_result(input int h, input bit to);
    logic [31:0] v;
    exp_count++;
    rd(2'd1, v);
    if (to) chk("width_tmo", v, 32'd0);
    else chk_rng("width", int'(v), h - 1, h + 1);
    rd(2'd0, v);
    chk("status", v, to ? 32'h6 : 32'h2);
    rd(2'd2, v);
    chk("count", v, 32'(exp_count));
  endtask

  task automatic measure(input int d, input int h, input bit sw);
    int p0, n;
    wr(2'd0, 32'h2);
    p0 = pulses;
    if (sw) wr(2'd3, 32'h2);
    else hw_start();
    wait_fall(p0);
    pulse_echo(d, h);
    wait_idle(TMO + 200, n);
    check_result(h, (d + h) > TMO);
  endtask

  initial begin
    logic [31:0] v;
    int n, p0, d, h;

    tick(4);
    chk("rst_trig_out", {31'd0, trig_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("rst_reg", v, 32'd0);
    end
    reset_n = 1'b1;
    tick(3);

    // Basic hardware-triggered measurement.
    measure(100, 750, 1'b0);

    // No echo at all: timeout from WAIT_RISE.
    wr(2'd0, 32'h2);
    p0 = pulses;
    hw_start();
    wait_fall(p0);
    wait_idle(TMO + 600, n);
    chk_rng("tmo_time", n, TMO - 10, TMO + 5);
    check_result(0, 1'b1);

    // Interrupt and W1C.
    wr(2'd3, 32'h1);
    measure(int'($urandom_range(10, 300)), int'($urandom_range(50, 900)), 1'b0);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h2);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd0, v);
    chk("status_clr", v, 32'd0);

    // Re-trigger and software start while busy are ignored.
    p0 = pulses;
    hw_start();
    tick(195);
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
    wait_fall(p0);
    wr(2'd3, 32'h2);
    pulse_echo(60, 300);
    wait_idle(TMO, n);
    check_result(300, 1'b0);
    tick(600);
    chk("no_queue", 32'(pulses - p0), 32'd1);

    // Hardware edge and software start in the same cycle.
    wr(2'd0, 32'h2);
    p0 = pulses;
    @(negedge clk);
    trig_in    = 1'b1;
    address    = 2'd3;
    writedata  = 32'h2;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    tick(1);
    trig_in = 1'b0;
    wait_fall(p0);
    pulse_echo(30, 200);
    wait_idle(TMO, n);
    check_result(200, 1'b0);
    tick(600);
    chk("one_meas", 32'(pulses - p0), 32'd1);

    // Echo already high before start: never rises, so timeout.
    echo = 1'b1;
    tick(10);
    wr(2'd0, 32'h2);
    p0 = pulses;
    hw_start();
    wait_fall(p0);
    wait_idle(TMO + 600, n);
    check_result(0, 1'b1);
    echo = 1'b0;
    tick(5);

    // Randomized runs: short echoes succeed, long ones time out.
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(5, 300));
      if ($urandom_range(0, 2) == 0) h = TMO + 20 - d + int'($urandom_range(0, 200));
      else h = int'($urandom_range(5, 1200));
      measure(d, h, i[0]);
      tick(5);
    end

    // Reset during the trigger pulse drops trig_out immediately.
    p0 = pulses;
    hw_start();
    tick(100);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_trig_async", {31'd0, trig_out}, 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(3);

    // Reset during MEASURE clears everything; then a software start.
    wr(2'd3, 32'h1);
    exp_count = 0;
    measure(40, 100, 1'b0);
    exp_count = 0;
    p0 = pulses;
    hw_start();
    wait_fall(p0);
    tick(50);
    echo = 1'b1;
    tick(100);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_meas_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_meas_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("rst_meas_reg", v, 32'd0);
    end
    tick(3);
    echo = 1'b0;
    reset_n = 1'b1;
    tick(5);
    measure(80, 400, 1'b1);
    chk("irq_after_rst", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
